// File: rtl/z80_ld8_pkg.sv
// rtl/z80_ld8_pkg.sv - shared encodings and helpers for the Z80 8-bit load sequencer
package z80_ld8_pkg;

    localparam logic [2:0] REG_B   = 3'd0;
    localparam logic [2:0] REG_C   = 3'd1;
    localparam logic [2:0] REG_D   = 3'd2;
    localparam logic [2:0] REG_E   = 3'd3;
    localparam logic [2:0] REG_H   = 3'd4;
    localparam logic [2:0] REG_L   = 3'd5;
    localparam logic [2:0] REG_HLI = 3'd6;
    localparam logic [2:0] REG_A   = 3'd7;

    localparam logic [7:0] OPC_HALT     = 8'h76;
    localparam logic [7:0] OPC_GRP_MASK = 8'hC0;
    localparam logic [7:0] OPC_GRP_LD   = 8'h40;
    localparam logic [7:0] OPC_IMM_MASK = 8'hC7;
    localparam logic [7:0] OPC_LD_N     = 8'h06;

    localparam logic BUS_RD = 1'b0;
    localparam logic BUS_WR = 1'b1;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_FETCH_N = 3'd2,
        ST_MEM_RD  = 3'd3,
        ST_MEM_WR  = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6,
        ST_TRAP    = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_RR   = 3'd0,
        CLS_R_HL = 3'd1,
        CLS_HL_R = 3'd2,
        CLS_IMM  = 3'd3,
        CLS_HALT = 3'd4,
        CLS_ILL  = 3'd5
    } ld_class_t;

    function automatic logic is_bus_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_FETCH_N) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

    // Value a register holds once the pending write-back has landed.
    function automatic logic [7:0] wb_merge(input logic [7:0] cur, input logic [2:0] sel,
                                            input logic we, input logic [2:0] waddr,
                                            input logic [7:0] wdata);
        return (we && (waddr == sel)) ? wdata : cur;
    endfunction

endpackage

// File: rtl/z80_ld8_decode.sv
// rtl/z80_ld8_decode.sv - combinational opcode classifier for the 8-bit load group
module z80_ld8_decode
    import z80_ld8_pkg::*;
(
    input  logic [7:0] ir,
    output ld_class_t  cls,
    output logic [2:0] ddd,
    output logic [2:0] sss
);

    always_comb begin
        ddd = ir[5:3];
        sss = ir[2:0];
        cls = CLS_ILL;
        // HALT sits inside the 01ddd_sss block, so it must win first.
        if (ir == OPC_HALT) begin
            cls = CLS_HALT;
        end else if ((ir & OPC_GRP_MASK) == OPC_GRP_LD) begin
            if (ir[2:0] == REG_HLI) begin
                cls = CLS_R_HL;
            end else if (ir[5:3] == REG_HLI) begin
                cls = CLS_HL_R;
            end else begin
                cls = CLS_RR;
            end
        end else if ((ir & OPC_IMM_MASK) == OPC_LD_N) begin
            cls = CLS_IMM;
        end
    end

endmodule

// File: rtl/z80_ld8_sequencer.sv
// rtl/z80_ld8_sequencer.sv - Z80 8-bit load-group sequencer (bus fetch, rf access, IP)
// Optional trace port enabled by defining Z80FI_TRACE_EN.
module z80_ld8_sequencer
    import z80_ld8_pkg::*;
#(
    parameter logic [15:0] RESET_IP = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic        bus_ack,
    input  logic [7:0]  bus_rdata,
    output logic [2:0]  rf_raddr,
    input  logic [7:0]  rf_rdata,
    input  logic [15:0] rf_hl,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [7:0]  rf_wdata,
    output logic [15:0] ip,
    output logic        retire,
    output logic        halted,
`ifdef Z80FI_TRACE_EN
    input  logic [7:0]  rf_snap_a,
    input  logic [7:0]  rf_snap_b,
    input  logic [7:0]  rf_snap_c,
    input  logic [7:0]  rf_snap_d,
    input  logic [7:0]  rf_snap_e,
    input  logic [7:0]  rf_snap_h,
    input  logic [7:0]  rf_snap_l,
    output logic        z80fi_valid,
    output logic [15:0] z80fi_insn,
    output logic [1:0]  z80fi_insn_len,
    output logic [15:0] z80fi_reg_ip_in,
    output logic [15:0] z80fi_reg_ip_out,
    output logic [7:0]  z80fi_reg_a_in,
    output logic [7:0]  z80fi_reg_b_in,
    output logic [7:0]  z80fi_reg_c_in,
    output logic [7:0]  z80fi_reg_d_in,
    output logic [7:0]  z80fi_reg_e_in,
    output logic [7:0]  z80fi_reg_h_in,
    output logic [7:0]  z80fi_reg_l_in,
    output logic [7:0]  z80fi_reg_a_out,
    output logic [7:0]  z80fi_reg_b_out,
    output logic [7:0]  z80fi_reg_c_out,
    output logic [7:0]  z80fi_reg_d_out,
    output logic [7:0]  z80fi_reg_e_out,
    output logic [7:0]  z80fi_reg_h_out,
    output logic [7:0]  z80fi_reg_l_out,
`endif
    output logic        trap
);

    state_t      state_q, state_d;
    logic [15:0] ip_q, ip_d;
    logic [7:0]  ir_q, ir_d;
    logic [7:0]  data_q, data_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_wr_q, bus_wr_d;
    logic [15:0] bus_addr_q, bus_addr_d;
    logic [7:0]  bus_wdata_q, bus_wdata_d;
    logic        halted_q, halted_d;
    logic        trap_q, trap_d;

    ld_class_t   cls;
    logic [2:0]  ddd;
    logic [2:0]  sss;
    logic        acked;

    z80_ld8_decode u_decode (
        .ir  (ir_q),
        .cls (cls),
        .ddd (ddd),
        .sss (sss)
    );

    assign acked = bus_req_q && bus_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            ip_q        <= RESET_IP;
            ir_q        <= 8'h00;
            data_q      <= 8'h00;
            bus_req_q   <= 1'b0;
            bus_wr_q    <= 1'b0;
            bus_addr_q  <= 16'h0000;
            bus_wdata_q <= 8'h00;
            halted_q    <= 1'b0;
            trap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ip_q        <= ip_d;
            ir_q        <= ir_d;
            data_q      <= data_d;
            bus_req_q   <= bus_req_d;
            bus_wr_q    <= bus_wr_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            halted_q    <= halted_d;
            trap_q      <= trap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ip_d     = ip_q;
        ir_d     = ir_q;
        data_d   = data_q;
        halted_d = halted_q;
        trap_d   = trap_q;
        case (state_q)
            ST_FETCH: begin
                if (acked) begin
                    ir_d    = bus_rdata;
                    ip_d    = ip_q + 16'd1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (cls)
                    CLS_RR: begin
                        data_d  = rf_rdata;
                        state_d = ST_WB;
                    end
                    CLS_R_HL: state_d = ST_MEM_RD;
                    CLS_HL_R: begin
                        data_d  = rf_rdata;
                        state_d = ST_MEM_WR;
                    end
                    CLS_IMM:  state_d = ST_FETCH_N;
                    CLS_HALT: begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end
                    default: begin
                        trap_d  = 1'b1;
                        state_d = ST_TRAP;
                    end
                endcase
            end
            ST_FETCH_N: begin
                if (acked) begin
                    data_d  = bus_rdata;
                    ip_d    = ip_q + 16'd1;
                    state_d = (ddd == REG_HLI) ? ST_MEM_WR : ST_WB;
                end
            end
            ST_MEM_RD: begin
                if (acked) begin
                    data_d  = bus_rdata;
                    state_d = ST_WB;
                end
            end
            ST_MEM_WR: begin
                if (acked) begin
                    state_d = ST_WB;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            default: state_d = state_q;
        endcase
    end

    // A request is raised one cycle after entering a bus state and dropped on
    // ack, which also guarantees the idle cycle between back-to-back accesses.
    always_comb begin
        bus_req_d   = bus_req_q;
        bus_wr_d    = bus_wr_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if (bus_req_q) begin
            bus_req_d = !bus_ack;
        end else if (is_bus_state(state_q)) begin
            bus_req_d   = 1'b1;
            bus_wr_d    = (state_q == ST_MEM_WR) ? BUS_WR : BUS_RD;
            bus_addr_d  = ((state_q == ST_FETCH) || (state_q == ST_FETCH_N)) ? ip_q : rf_hl;
            bus_wdata_d = data_q;
        end
    end

    always_comb begin
        rf_we  = 1'b0;
        retire = 1'b0;
        if (state_q == ST_WB) begin
            retire = 1'b1;
            rf_we  = (ddd != REG_HLI);
        end
    end

    assign rf_raddr  = sss;
    assign rf_waddr  = ddd;
    assign rf_wdata  = data_q;
    assign bus_req   = bus_req_q;
    assign bus_wr    = bus_wr_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign ip        = ip_q;
    assign halted    = halted_q;
    assign trap      = trap_q;

`ifdef Z80FI_TRACE_EN
    logic [15:0] tr_insn_q, tr_insn_d;
    logic [1:0]  tr_len_q, tr_len_d;
    logic [15:0] tr_ip_in_q, tr_ip_in_d;
    logic [55:0] tr_regs_in_q, tr_regs_in_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            tr_insn_q    <= 16'h0000;
            tr_len_q     <= 2'd0;
            tr_ip_in_q   <= 16'h0000;
            tr_regs_in_q <= 56'h0;
        end else begin
            tr_insn_q    <= tr_insn_d;
            tr_len_q     <= tr_len_d;
            tr_ip_in_q   <= tr_ip_in_d;
            tr_regs_in_q <= tr_regs_in_d;
        end
    end

    // The first FETCH cycle never has a request outstanding, so it marks entry.
    always_comb begin
        tr_insn_d    = tr_insn_q;
        tr_len_d     = tr_len_q;
        tr_ip_in_d   = tr_ip_in_q;
        tr_regs_in_d = tr_regs_in_q;
        if ((state_q == ST_FETCH) && !bus_req_q) begin
            tr_ip_in_d   = ip_q;
            tr_regs_in_d = {rf_snap_a, rf_snap_b, rf_snap_c, rf_snap_d,
                            rf_snap_e, rf_snap_h, rf_snap_l};
        end
        if ((state_q == ST_FETCH) && acked) begin
            tr_insn_d = {8'h00, bus_rdata};
            tr_len_d  = 2'd1;
        end
        if ((state_q == ST_FETCH_N) && acked) begin
            tr_insn_d[15:8] = bus_rdata;
            tr_len_d        = 2'd2;
        end
    end

    assign z80fi_valid      = retire;
    assign z80fi_insn       = tr_insn_q;
    assign z80fi_insn_len   = tr_len_q;
    assign z80fi_reg_ip_in  = tr_ip_in_q;
    assign z80fi_reg_ip_out = ip_q;
    assign z80fi_reg_a_in   = tr_regs_in_q[55:48];
    assign z80fi_reg_b_in   = tr_regs_in_q[47:40];
    assign z80fi_reg_c_in   = tr_regs_in_q[39:32];
    assign z80fi_reg_d_in   = tr_regs_in_q[31:24];
    assign z80fi_reg_e_in   = tr_regs_in_q[23:16];
    assign z80fi_reg_h_in   = tr_regs_in_q[15:8];
    assign z80fi_reg_l_in   = tr_regs_in_q[7:0];
    assign z80fi_reg_a_out  = wb_merge(rf_snap_a, REG_A, rf_we, rf_waddr, rf_wdata);
    assign z80fi_reg_b_out  = wb_merge(rf_snap_b, REG_B, rf_we, rf_waddr, rf_wdata);
    assign z80fi_reg_c_out  = wb_merge(rf_snap_c, REG_C, rf_we, rf_waddr, rf_wdata);
    assign z80fi_reg_d_out  = wb_merge(rf_snap_d, REG_D, rf_we, rf_waddr, rf_wdata);
    assign z80fi_reg_e_out  = wb_merge(rf_snap_e, REG_E, rf_we, rf_waddr, rf_wdata);
    assign z80fi_reg_h_out  = wb_merge(rf_snap_h, REG_H, rf_we, rf_waddr, rf_wdata);
    assign z80fi_reg_l_out  = wb_merge(rf_snap_l, REG_L, rf_we, rf_waddr, rf_wdata);
`endif

endmodule
